// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the two-master Wishbone RAM arbiter.
// Holds the FSM state encoding and the Wishbone data/address/select widths.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    localparam int WB_DW   = 32;
    localparam int WB_AW   = 32;
    localparam int WB_SELW = 4;

endpackage

// File: rtl/wb_arb_timeout_cnt.sv
// Empty elaboration guard kept next to the watchdog sources.
// The watchdog itself is wb_timeout_cnt in wb_timeout_cnt.sv.
module wb_arb_timeout_cnt_unused_guard;
endmodule

// File: rtl/wb_timeout_cnt.sv
// Per-transfer watchdog: counts stalled cycles and flags the last allowed one.
// Ports: clk_i, rst_i (async, active-high), en_i (stall cycle), clr_i (restart),
//        expire_o (high on the stall cycle where the count reaches the limit).
module wb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Expiry is only meaningful on a cycle that is still stalled.
    assign expire_o = en_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the OpenRAM wrapper.
// Ports: wb_clk_i/wb_rst_i, m0_*/m1_* master buses, s_* slave bus to the RAM.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,

    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [WB_SELW-1:0] m0_sel_i,
    input  logic [WB_AW-1:0]   m0_adr_i,
    input  logic [WB_DW-1:0]   m0_dat_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic [WB_DW-1:0]   m0_dat_o,

    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [WB_SELW-1:0] m1_sel_i,
    input  logic [WB_AW-1:0]   m1_adr_i,
    input  logic [WB_DW-1:0]   m1_dat_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [WB_DW-1:0]   m1_dat_o,

    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [WB_SELW-1:0] s_sel_o,
    output logic [WB_AW-1:0]   s_adr_o,
    output logic [WB_DW-1:0]   s_dat_o,
    input  logic               s_ack_i,
    input  logic [WB_DW-1:0]   s_dat_i
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_gnt_q;
    logic       last_gnt_d;

    logic req0;
    logic req1;
    logic in_gnt;
    logic tmo_en;
    logic tmo_clr;
    logic expire;

    assign req0   = m0_cyc_i & m0_stb_i;
    assign req1   = m1_cyc_i & m1_stb_i;
    assign in_gnt = (state_q == GNT0) | (state_q == GNT1);

    // Only a strobed, un-acked cycle in a grant state counts as a stall.
    assign tmo_en  = in_gnt & s_stb_o & ~s_ack_i;
    assign tmo_clr = ~in_gnt | ~s_stb_o | s_ack_i | (state_d != state_q);

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_tmo (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .en_i     (tmo_en),
        .clr_i    (tmo_clr),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 & req1) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (expire) begin
                    state_d = ABORT;
                end else if (!m0_cyc_i) begin
                    state_d = req1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (expire) begin
                    state_d = ABORT;
                end else if (!m1_cyc_i) begin
                    state_d = req0 ? GNT0 : IDLE;
                end
            end
            ABORT: begin
                // last_gnt still names the aborted master.
                if (!last_gnt_q && !m0_cyc_i) begin
                    state_d = req1 ? GNT1 : IDLE;
                end else if (last_gnt_q && !m1_cyc_i) begin
                    state_d = req0 ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            if (state_d == GNT0) last_gnt_d = 1'b0;
            if (state_d == GNT1) last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (state_q == GNT0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = expire;
            m0_dat_o = s_dat_i;
        end else if (state_q == GNT1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = expire;
            m1_dat_o = s_dat_i;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed self-checking bench for wb_ram_arbiter.
// Inputs change 1ns after posedge; outputs are sampled 1ns later.
module tb_wb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_wdat;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_wdat;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),
        .m0_sel_i (m0_sel),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_wdat),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m0_dat_o (m0_rdat),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),
        .m1_sel_i (m1_sel),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_wdat),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .m1_dat_o (m1_rdat),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_rdat)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic m0_req(input logic on);
        m0_cyc = on;
        m0_stb = on;
    endtask

    task automatic m1_req(input logic on);
        m1_cyc = on;
        m1_stb = on;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF;
        m0_adr = '0; m0_wdat = 32'h1111_1111;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF;
        m1_adr = '0; m1_wdat = 32'h2222_2222;
        s_ack  = 0; s_rdat = 32'h5555_AAAA;

        // Reset state
        tick();
        chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rst_s_adr", s_adr, 32'd0);
        chk("rst_m0_dat", m0_rdat, 32'd0);
        rst = 1'b0;
        tick();

        // Single m0 read, ack on second strobe cycle
        m0_req(1); m0_adr = 32'h3000_0010;
        settle();
        chk("rd_arb_stb", {31'd0, s_stb}, 32'd0);
        tick();
        chk("rd_stb", {31'd0, s_stb}, 32'd1);
        chk("rd_adr", s_adr, 32'h3000_0010);
        chk("rd_noack", {31'd0, m0_ack}, 32'd0);
        tick();
        s_ack = 1; s_rdat = 32'hA5A5_1234;
        settle();
        chk("rd_ack", {31'd0, m0_ack}, 32'd1);
        chk("rd_dat", m0_rdat, 32'hA5A5_1234);
        chk("rd_m1_ack", {31'd0, m1_ack}, 32'd0);
        tick();
        m0_req(0); s_ack = 0;
        tick();

        // Simultaneous first request after reset
        do_reset();
        m0_adr = 32'h0000_0100;
        m1_adr = 32'h0000_0200; m1_we = 1;
        m1_wdat = 32'hDEAD_BEEF; m1_sel = 4'b0011;
        m0_req(1); m1_req(1);
        settle();
        chk("sim_idle", {31'd0, s_cyc}, 32'd0);
        tick();
        chk("sim_first", s_adr, 32'h0000_0100);
        s_ack = 1;
        settle();
        chk("sim_m0_ack", {31'd0, m0_ack}, 32'd1);
        chk("sim_m1_noack", {31'd0, m1_ack}, 32'd0);
        tick();
        m0_req(0); s_ack = 0;
        tick();
        chk("sim_gnt1_cyc", {31'd0, s_cyc}, 32'd1);
        chk("sim_gnt1_adr", s_adr, 32'h0000_0200);
        chk("sim_wdat", s_wdat, 32'hDEAD_BEEF);
        chk("sim_sel", {28'd0, s_sel}, 32'h3);
        chk("sim_we", {31'd0, s_we}, 32'd1);
        s_ack = 1;
        settle();
        chk("sim_m1_ack", {31'd0, m1_ack}, 32'd1);
        tick();
        m1_req(0); s_ack = 0; m1_we = 0;
        tick();
        tick();

        // Round-robin with continuous re-requests; last grant was m1
        m0_req(1); m1_req(1);
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] want;
            want = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            chk($sformatf("rr_%0d", i), s_adr, want);
            s_ack = 1;
            tick();
            s_ack = 0;
            if (i % 2 == 0) m0_req(0); else m1_req(0);
            tick();
            if (i % 2 == 0) m0_req(1); else m1_req(1);
        end
        m0_req(0); m1_req(0);
        tick();
        tick();

        // Slave timeout: err on the 16th stalled strobe cycle
        m0_req(1);
        tick();
        chk("tmo_stb", {31'd0, s_stb}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("tmo_noerr_%0d", i), {31'd0, m0_err}, 32'd0);
            tick();
        end
        chk("tmo_err", {31'd0, m0_err}, 32'd1);
        chk("tmo_err_noack", {31'd0, m0_ack}, 32'd0);
        tick();
        chk("tmo_abort_cyc", {31'd0, s_cyc}, 32'd0);
        chk("tmo_err_1cyc", {31'd0, m0_err}, 32'd0);
        s_ack = 1;
        settle();
        chk("tmo_late_ack", {31'd0, m0_ack}, 32'd0);
        tick();
        s_ack = 0; m0_req(0);
        tick();
        tick();

        // Ack arriving on the expiry cycle wins
        m0_req(1);
        tick();
        for (int i = 0; i < 15; i++) tick();
        s_ack = 1;
        settle();
        chk("race_ack", {31'd0, m0_ack}, 32'd1);
        chk("race_noerr", {31'd0, m0_err}, 32'd0);
        tick();
        s_ack = 0; m0_req(0);
        tick();
        tick();

        // Asynchronous reset mid-cycle during GNT1
        m1_req(1);
        tick();
        chk("mrst_gnt1", {31'd0, s_stb}, 32'd1);
        s_ack = 1; s_rdat = 32'hCAFE_F00D;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("mrst_s_stb", {31'd0, s_stb}, 32'd0);
        chk("mrst_s_adr", s_adr, 32'd0);
        chk("mrst_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("mrst_m1_dat", m1_rdat, 32'd0);
        #1;
        rst = 1'b0; s_ack = 0;
        m0_req(1);
        tick();
        chk("mrst_contend", s_adr, 32'h0000_0100);
        m0_req(0); m1_req(0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule
